// File: rtl/aes_decrypter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys regenerated on the fly,
// with an optional cache of the round-10 key for a repeated cipher key.
module aes_decrypter #(
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // state   | meaning
    // IDLE    | waiting for ciphertext/key
    // KEY_EXP | forward expansion to the round-10 key
    // ROUNDS  | inverse rounds 9..0, key schedule run backwards
    // FINAL   | register the plaintext onto out_data
    // DONE    | holding out_valid until out_ready
    typedef enum logic [2:0] {IDLE, KEY_EXP, ROUNDS, FINAL, DONE} state_t;

    state_t       st, st_next;
    logic [127:0] data_q, key_q, key_seed, cache_key, cache_k10;
    logic [3:0]   round_q;
    logic         cache_v, hit;
    logic [127:0] key_fwd_w, key_inv_w, round_add, round_out;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // byte 0 of a word sits in bits [7:0], so RotWord moves byte 1 down to byte 0
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[7:0]), sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[31:0] ^ sub_rot(k[127:96]) ^ {24'h0, rcon(r)};
        n1 = k[63:32] ^ n0;
        n2 = k[95:64] ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[127:96] ^ k[95:64];
        p2 = k[95:64] ^ k[63:32];
        p1 = k[63:32] ^ k[31:0];
        p0 = k[31:0] ^ sub_rot(p3) ^ {24'h0, rcon(r)};
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int row, col, src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            row = i % 4;
            col = i / 4;
            src = row + 4 * ((col + 4 - row) % 4);
            o[8*i +: 8] = inv_sbox(s[8*src +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign key_fwd_w = key_fwd(key_q, round_q);
    assign key_inv_w = key_inv(key_q, round_q + 4'd1);
    assign round_add = inv_shift_sub(data_q) ^ key_inv_w;
    assign round_out = (round_q == 4'd0) ? round_add : inv_mix(round_add);
    assign in_ready  = (st == IDLE);
    assign busy      = (st != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else      st <= st_next;
    end

    always_comb begin
        st_next = st;
        hit     = KEY_CACHE_EN && cache_v && (in_key == cache_key);
        case (st)
            IDLE:    if (in_valid) st_next = hit ? ROUNDS : KEY_EXP;
            KEY_EXP: if (round_q == 4'd10) st_next = ROUNDS;
            ROUNDS:  if (round_q == 4'd0) st_next = FINAL;
            FINAL:   st_next = DONE;
            DONE:    if (out_ready) st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            key_q     <= '0;
            key_seed  <= '0;
            cache_key <= '0;
            cache_k10 <= '0;
            cache_v   <= 1'b0;
            round_q   <= 4'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    key_seed <= in_key;
                    if (hit) begin
                        data_q  <= in_data ^ cache_k10;
                        key_q   <= cache_k10;
                        round_q <= 4'd9;
                    end else begin
                        data_q  <= in_data;
                        key_q   <= in_key;
                        round_q <= 4'd1;
                    end
                end
                KEY_EXP: begin
                    key_q <= key_fwd_w;
                    if (round_q == 4'd10) begin
                        data_q    <= data_q ^ key_fwd_w;
                        cache_k10 <= key_fwd_w;
                        cache_key <= key_seed;
                        cache_v   <= 1'b1;
                        round_q   <= 4'd9;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ROUNDS: begin
                    data_q <= round_out;
                    key_q  <= key_inv_w;
                    if (round_q != 4'd0) round_q <= round_q - 4'd1;
                end
                FINAL: begin
                    out_data  <= data_q;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypter.sv
// Bench for aes_decrypter: table-driven reference AES inverse cipher, per-cycle handshake model,
// directed FIPS-197 vectors, backpressure, mid-operation reset and a no-cache instance.
module tb_aes_decrypter;

    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] Z_CT   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;
    localparam logic [127:0] ZERO   = 128'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [127:0] in_data = '0, in_key = '0, out_data;

    logic         rst2 = 1'b1;
    logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, busy2;
    logic [127:0] in_data2 = '0, in_key2 = '0, out_data2;
    logic         nc_done = 1'b0;

    int checks = 0;
    int errors = 0;

    aes_decrypter #(.KEY_CACHE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_decrypter #(.KEY_CACHE_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_key(in_key2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference tables built with the classic generator walk (p times 3, q divided by 3).
    logic [7:0] sb[256];
    logic [7:0] isb[256];

    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input int b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Textbook inverse cipher over a fully pre-expanded key schedule.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
        logic [7:0]   rk[11][16];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   tmp[4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) rk[0][i] = key[8*i +: 8];
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tmp[0] = sb[rk[r-1][13]] ^ rc;
            tmp[1] = sb[rk[r-1][14]];
            tmp[2] = sb[rk[r-1][15]];
            tmp[3] = sb[rk[r-1][12]];
            for (int i = 0; i < 16; i++) begin
                if (i < 4) rk[r][i] = rk[r-1][i] ^ tmp[i];
                else       rk[r][i] = rk[r-1][i] ^ rk[r][i-4];
            end
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ rk[10][i];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int i = 0; i < 16; i++)
                t[i] = isb[s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]] ^ rk[rnd][i];
            for (int c = 0; c < 4; c++) begin
                if (rnd > 0) begin
                    s[4*c]   = gm(t[4*c], 14) ^ gm(t[4*c+1], 11) ^ gm(t[4*c+2], 13) ^ gm(t[4*c+3], 9);
                    s[4*c+1] = gm(t[4*c], 9)  ^ gm(t[4*c+1], 14) ^ gm(t[4*c+2], 11) ^ gm(t[4*c+3], 13);
                    s[4*c+2] = gm(t[4*c], 13) ^ gm(t[4*c+1], 9)  ^ gm(t[4*c+2], 14) ^ gm(t[4*c+3], 11);
                    s[4*c+3] = gm(t[4*c], 11) ^ gm(t[4*c+1], 13) ^ gm(t[4*c+2], 9)  ^ gm(t[4*c+3], 14);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // Transaction-level model of the cached-key instance: busy span, result timing, cache contents.
    logic         m_busy = 1'b0, m_valid = 1'b0, m_miss = 1'b0, m_cv = 1'b0;
    int           m_elapsed = 0, m_lat = 0;
    logic [127:0] m_data = '0, m_key = '0, m_ckey = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cv    <= 1'b0;
        end else if (m_busy) begin
            if (m_valid) begin
                if (out_ready) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                end
            end else begin
                m_elapsed <= m_elapsed + 1;
                if (m_miss && m_elapsed + 1 == 10) begin
                    m_cv   <= 1'b1;
                    m_ckey <= m_key;
                end
                if (m_elapsed + 1 == m_lat) m_valid <= 1'b1;
            end
        end else if (in_valid) begin
            m_busy    <= 1'b1;
            m_elapsed <= 0;
            m_miss    <= !(m_cv && in_key == m_ckey);
            m_lat     <= (m_cv && in_key == m_ckey) ? 11 : 21;
            m_key     <= in_key;
            m_data    <= ref_decrypt(in_data, in_key);
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", 128'(in_ready), 128'(!m_busy));
        check("cyc_busy", 128'(busy), 128'(m_busy));
        check("cyc_out_valid", 128'(out_valid), 128'(m_valid));
        if (m_valid) check("cyc_out_data", out_data, m_data);
    end

    task automatic send(input logic [127:0] d, input logic [127:0] k, input int lat,
                        input logic [127:0] exp, input bit garbage, input int hold);
        bit rdy, got;
        int n;
        in_data   = d;
        in_key    = k;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!rdy) begin
            check("accept_timeout", 128'(rdy), 128'(1));
            return;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (garbage && (n == 5 || n == 15)) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_key   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            got = out_valid;
        end
        check("latency", 128'(n), 128'(lat));
        check("plaintext", out_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_data", out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_out", 128'(in_ready), 128'(1));
        check("valid_after_out", 128'(out_valid), 128'(0));
    endtask

    initial begin
        bit rdy;
        build_sbox();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, ZERO);
        check("rst_busy", 128'(busy), 128'(0));
        check("model_c1", ref_decrypt(C1_CT, C1_KEY), C1_PT);
        check("model_zero", ref_decrypt(Z_CT, ZERO), ZERO);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(C1_CT, C1_KEY, 21, C1_PT, 1'b1, 0);
        send(C1_CT, C1_KEY, 11, C1_PT, 1'b0, 0);
        send(Z_CT, ZERO, 21, ZERO, 1'b0, 0);
        send(Z_CT, ZERO, 11, ZERO, 1'b0, 5);
        send(C1_CT, C1_KEY, 21, C1_PT, 1'b0, 0);

        // abort a zero-key block four rounds into ROUNDS, after its key reached the cache
        in_data  = Z_CT;
        in_key   = ZERO;
        in_valid = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("mid_busy", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_out_data", out_data, ZERO);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(Z_CT, ZERO, 21, ZERO, 1'b0, 0);

        for (int i = 0; i < 1000 && !nc_done; i++) @(posedge clk);
        if (!nc_done) check("nc_timeout", 128'(nc_done), 128'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit rdy, got;
        int n;
        in_data2 = C1_CT;
        in_key2  = C1_KEY;
        #2 rst2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            in_valid2 = 1'b1;
            rdy = 1'b0;
            for (int i = 0; i < 50 && !rdy; i++) begin
                @(negedge clk);
                rdy = in_ready2;
                @(posedge clk);
            end
            #1 in_valid2 = 1'b0;
            check("nc_busy", 128'(busy2), 128'(1));
            got = 1'b0;
            n = 0;
            while (!got && n < 60) begin
                @(posedge clk);
                n++;
                #1 got = out_valid2;
            end
            check("nc_latency", 128'(n), 128'(21));
            check("nc_plaintext", out_data2, C1_PT);
            @(posedge clk);
            #1;
        end
        nc_done = 1'b1;
    end

endmodule

// File: doc/aes_decrypter.md
Name: aes_decrypter

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher). It is the receive-side counterpart of the encryption datapath in the encryption_functions package.
- It accepts one 128-bit ciphertext and one 128-bit cipher key per valid/ready handshake and returns the plaintext on a second valid/ready handshake.
- It computes one round per clock. Round keys come from an on-the-fly forward expansion, then the inverse key schedule.
- An optional key cache skips the forward expansion when the key repeats.

Parameters:
- KEY_CACHE_EN, 1, 1 = skip forward key expansion when in_key equals the last expanded key; 0 = always expand.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  ciphertext/key valid.
- in_ready  output  1  block can accept new input.
- in_data  input  128  ciphertext; byte i = bits [8i+7:8i], state byte i = row i%4, column i/4.
- in_key  input  128  cipher key, same byte packing.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  128  plaintext, same packing.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, cache valid flag=0, round counter=0. Reset asserted mid-operation aborts immediately with no output. Any accepted input is discarded.
- IDLE, in_ready=1:
  - On in_valid&&in_ready, latch in_data into state and in_key into key register.
  - Cache hit (KEY_CACHE_EN=1, cache valid, in_key==cached key): load the stored round-10 key, XOR it into the state, go to ROUNDS.
  - Otherwise go to KEY_EXP.
- KEY_EXP, 10 cycles, counter 1..10. Each cycle:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Word j = bytes 4j..4j+3.
  - On cycle 10: state ^= key10, store key10 and in_key in the cache (cache valid=1), go to ROUNDS.
- ROUNDS, 10 cycles, counter r=9 down to 0. Each cycle:
  - state = InvSubBytes(InvShiftRows(state)) ^ k_r, where k_r is derived from k_{r+1} by the inverse schedule: w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(w3))^Rcon[r+1].
  - InvMixColumns is applied after the key add for r=9..1 and not for r=0.
  - InvShiftRows: out[i] takes byte from column (c - row) mod 4, same row. Concretely out[1]=in[13], out[5]=in[1], out[2]=in[10], out[7]=in[11].
  - InvMixColumns matrix: 0e 0b 0d 09 circulant over GF(2^8), reduction polynomial 0x11b.
  - After r=0: out_data=state, out_valid=1, go to DONE.
- DONE: out_valid and out_data held stable until out_ready=1. On the handshake edge: out_valid=0, go to IDLE. in_ready=1 in the next cycle; no overlap of input and output.
- Latency: out_valid rises 21 edges after the input handshake edge (cache miss) or 11 edges (cache hit).
- Throughput: at most one block per 22 cycles (miss) or 12 cycles (hit) with out_ready tied high.
- in_valid while not in IDLE is ignored; in_data and in_key may change freely.
- The cache updates only on a completed KEY_EXP. A reset clears cache valid.

Test Plan:
- FIPS-197 C.1 vector, cold cache:
  - Stimulus: in_key=128'h0f0e0d0c0b0a09080706050403020100, in_data=128'h5ac5b47080b7cdd830047b6ad8e0c469.
  - Response: out_data=128'hffeeddccbbaa99887766554433221100, out_valid exactly 21 cycles after accept.
- Repeat the same key with KEY_CACHE_EN=1 -> identical plaintext, latency 11. With KEY_CACHE_EN=0 -> latency 21.
- Zero-key vector, then key change:
  - Stimulus: in_key=0, in_data=128'h2e2b34ca59fa4c883b2c8aefd44be966.
  - Response: out_data=0, latency 21 (cache miss after the key change).
- Output backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout. Release -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst low during ROUNDS cycle 4 -> outputs go to reset values immediately. A new block then decrypts correctly with 21-cycle latency (cache cleared).
- Ignored input: pulse in_valid with garbage during KEY_EXP and ROUNDS -> no effect on the result of the C.1 vector.
